// File: rtl/jk_cmd_seq.sv
// Queued J/K command sequencer for a downstream JK flip-flop; optional Q checker under JK_SEQ_CHECK_EN.
// Latency: 1 cycle from accepting edge to first J/K cycle; consecutive commands play out gapless.
// Backpressure: cmd_ready drops when the DEPTH-entry command FIFO is full (registered count only).
module jk_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             cmd_done,
  input  logic             q_in,
  output logic             mismatch
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 + CNT_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state_q, state_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             j_q, j_d, k_q, k_d;
  logic             push, pop, empty;
  logic [EW-1:0]    head;

  assign cmd_ready = (count_q < FULL_CNT);
  assign empty     = (count_q == '0);
  assign push      = rst & cmd_valid & cmd_ready;
  assign head      = mem_q[rd_ptr_q];
  assign j         = j_q;
  assign k         = k_q;
  assign busy      = (state_q == ISSUE) || !empty;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    j_d      = j_q;
    k_d      = k_q;
    pop      = 1'b0;
    cmd_done = 1'b0;
    case (state_q)
      IDLE: begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (!empty) pop = 1'b1;
      end
      ISSUE: begin
        if (rem_q != '0) begin
          rem_d = rem_q - CNT_W'(1);
        end else begin
          cmd_done = 1'b1;
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            j_d     = 1'b0;
            k_d     = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Loading on the same edge as the pop keeps back-to-back commands bubble-free.
    if (pop) begin
      state_d = ISSUE;
      rem_d   = head[CNT_W-1:0];
      j_d     = head[CNT_W+1];
      k_d     = head[CNT_W];
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_op, cmd_len};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rem_q    <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      j_q      <= j_d;
      k_q      <= k_d;
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef JK_SEQ_CHECK_EN
  logic q_exp_q, q_exp_d, mismatch_q, mismatch_d;

  always_comb begin
    q_exp_d    = (j_q & ~q_exp_q) | (~k_q & q_exp_q);
    mismatch_d = mismatch_q | (q_in != q_exp_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_exp_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      q_exp_q    <= q_exp_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  logic unused_q_in;
  assign unused_q_in = q_in;
  assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Randomized and directed bench for jk_cmd_seq against a command-timeline reference model.
module tb_jk_cmd_seq;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;
  logic             j, k, busy, cmd_done, q_in, mismatch;

  jk_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .j(j), .k(k), .busy(busy),
    .cmd_done(cmd_done), .q_in(q_in), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: every accepted command with its accept edge and the edge after which it starts.
  int         a_m [1024];
  int         s_m [1024];
  int         l_m [1024];
  logic [1:0] o_m [1024];
  int         n_m = 0;
  int         first_m = 0;
  int         cur = 0;
  logic       q_model = 1'b0;
  logic       m_model = 1'b0;

  function automatic logic [1:0] op_jk(input logic [1:0] op);
    case (op)
      2'd0:    return 2'b00;  // HOLD
      2'd1:    return 2'b01;  // RESET
      2'd2:    return 2'b10;  // SET
      default: return 2'b11;  // TOGGLE
    endcase
  endfunction

  function automatic logic [1:0] exp_jk(input int t);
    for (int i = first_m; i < n_m; i++)
      if (t >= s_m[i] && t <= s_m[i] + l_m[i]) return op_jk(o_m[i]);
    return 2'b00;
  endfunction

  function automatic logic exp_done(input int t);
    for (int i = first_m; i < n_m; i++)
      if (t == s_m[i] + l_m[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_busy(input int t);
    for (int i = first_m; i < n_m; i++)
      if (t >= a_m[i] && t <= s_m[i] + l_m[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_count(input int t);
    int c = 0;
    for (int i = first_m; i < n_m; i++) begin
      if (a_m[i] <= t) c++;
      if (s_m[i] <= t) c--;
    end
    return c;
  endfunction

  function automatic logic [5:0] exp_vec(input int t);
    return {exp_jk(t), exp_done(t), exp_busy(t), (exp_count(t) < DEPTH), m_model};
  endfunction

  function automatic void model_push(input int t, input logic [1:0] op, input int len);
    int e;
    a_m[n_m] = t;
    o_m[n_m] = op;
    l_m[n_m] = len;
    if (n_m > first_m) begin
      e = s_m[n_m-1] + l_m[n_m-1] + 1;
      s_m[n_m] = (t < e) ? e : t + 1;
    end else begin
      s_m[n_m] = t + 1;
    end
    n_m++;
  endfunction

  // One clock cycle: apply inputs, advance the model across the edge, stop at the negedge.
  task automatic drive_cycle(input logic v, input logic [1:0] op, input int len,
                             input logic r, input logic qflip, output logic acc);
    logic [1:0] pjk;
    rst       = r;
    cmd_valid = v;
    cmd_op    = op;
    cmd_len   = CNT_W'(len);
`ifdef JK_SEQ_CHECK_EN
    q_in = q_model ^ qflip;
`else
    q_in = 1'($urandom_range(0, 1)) ^ qflip;
`endif
    acc = r && v && (exp_count(cur) < DEPTH);
    pjk = exp_jk(cur);
    @(posedge clk);
    cur++;
    if (!r) begin
      first_m = n_m;
      q_model = 1'b0;
      m_model = 1'b0;
    end else begin
`ifdef JK_SEQ_CHECK_EN
      if (q_in != q_model) m_model = 1'b1;
`endif
      case (pjk)
        2'b01:   q_model = 1'b0;
        2'b10:   q_model = 1'b1;
        2'b11:   q_model = ~q_model;
        default: q_model = q_model;
      endcase
      if (acc) model_push(cur, op, len);
    end
    @(negedge clk);
  endtask

  function automatic logic [5:0] obs_vec();
    return {j, k, cmd_done, busy, cmd_ready, mismatch};
  endfunction

  task automatic test_reset();
    logic acc;
    logic [5:0] o, e;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 2'd2, 3, 1'b0, 1'b0, acc);
      o = obs_vec();
      checks++;
      if (o !== 6'b000010) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got=%b want=000010", cur, o);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 2'd0, 0, 1'b1, 1'b0, acc);
      o = obs_vec();
      e = exp_vec(cur);
      checks++;
      if (o !== e || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_empty cyc=%0d got=%b want=%b", cur, o, e);
      end
    end
  endtask

  task automatic test_single_set();
    logic acc;
    logic [5:0] o, e;
    int nset = 0;
    drive_cycle(1'b1, 2'd2, 2, 1'b1, 1'b0, acc);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 2'd0, 0, 1'b1, 1'b0, acc);
      o = obs_vec();
      e = exp_vec(cur);
      if ({j, k} === 2'b10) nset++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL single_set cyc=%0d got=%b want=%b", cur, o, e);
      end
    end
    checks++;
    if (nset !== 3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_set_len set_cycles=%0d busy=%b want 3 and 0", nset, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic [5:0] o, e;
    int n11 = 0, n01 = 0, f11 = -1, f01 = -1;
    drive_cycle(1'b1, 2'd3, 3, 1'b1, 1'b0, acc);
    drive_cycle(1'b1, 2'd1, 0, 1'b1, 1'b0, acc);
    o = obs_vec();
    e = exp_vec(cur);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL b2b cyc=%0d got=%b want=%b", cur, o, e);
    end
    if ({j, k} === 2'b11) begin n11++; f11 = cur; end
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 2'd0, 0, 1'b1, 1'b0, acc);
      o = obs_vec();
      e = exp_vec(cur);
      if ({j, k} === 2'b11) begin n11++; if (f11 < 0) f11 = cur; end
      if ({j, k} === 2'b01) begin n01++; if (f01 < 0) f01 = cur; end
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b cyc=%0d got=%b want=%b", cur, o, e);
      end
    end
    checks++;
    if (n11 !== 4 || n01 !== 1 || f01 !== f11 + 4) begin
      failures++;
      $display("FAIL b2b_shape toggle=%0d reset=%0d gap=%0d want 4 1 4", n11, n01, f01 - f11);
    end
  endtask

  task automatic test_full();
    logic acc;
    logic [5:0] o, e;
    drive_cycle(1'b1, 2'd0, 15, 1'b1, 1'b0, acc);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 2'($urandom_range(0, 3)), $urandom_range(0, 2), 1'b1, 1'b0, acc);
      o = obs_vec();
      e = exp_vec(cur);
      checks++;
      if (o !== e || !acc) begin
        failures++;
        $display("FAIL full_push cyc=%0d got=%b want=%b", cur, o, e);
      end
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready got=%b want=0", cmd_ready);
    end
    for (int i = 0; i < 30; i++) begin
      drive_cycle(1'b0, 2'd0, 0, 1'b1, 1'b0, acc);
      o = obs_vec();
      e = exp_vec(cur);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL full_drain cyc=%0d got=%b want=%b", cur, o, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic acc;
    logic [5:0] o, e;
    int active = 0;
    drive_cycle(1'b1, 2'd2, 7, 1'b1, 1'b0, acc);
    drive_cycle(1'b1, 2'd3, 1, 1'b1, 1'b0, acc);
    drive_cycle(1'b1, 2'd1, 1, 1'b1, 1'b0, acc);
    drive_cycle(1'b0, 2'd0, 0, 1'b0, 1'b0, acc);
    checks++;
    if ({j, k, busy, cmd_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL mid_reset got jkbr=%b want=0001", {j, k, busy, cmd_ready});
    end
    for (int i = 0; i < 15; i++) begin
      drive_cycle(1'b0, 2'd0, 0, 1'b1, 1'b0, acc);
      o = obs_vec();
      e = exp_vec(cur);
      if (j !== 1'b0 || k !== 1'b0 || busy !== 1'b0) active++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mid_reset_after cyc=%0d got=%b want=%b", cur, o, e);
      end
    end
    checks++;
    if (active !== 0) begin
      failures++;
      $display("FAIL mid_reset_discard active_cycles=%0d want=0", active);
    end
  endtask

`ifdef JK_SEQ_CHECK_EN
  task automatic test_checker();
    logic acc;
    drive_cycle(1'b1, 2'd2, 0, 1'b1, 1'b0, acc);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 2'd0, 0, 1'b1, 1'b0, acc);
    checks++;
    if (mismatch !== 1'b0) begin
      failures++;
      $display("FAIL checker_clean got=%b want=0", mismatch);
    end
    drive_cycle(1'b0, 2'd0, 0, 1'b1, 1'b1, acc);
    checks++;
    if (mismatch !== 1'b1) begin
      failures++;
      $display("FAIL checker_set got=%b want=1", mismatch);
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 2'd0, 0, 1'b1, 1'b0, acc);
    checks++;
    if (mismatch !== 1'b1) begin
      failures++;
      $display("FAIL checker_sticky got=%b want=1", mismatch);
    end
    drive_cycle(1'b0, 2'd0, 0, 1'b0, 1'b0, acc);
    checks++;
    if (mismatch !== 1'b0) begin
      failures++;
      $display("FAIL checker_clear got=%b want=0", mismatch);
    end
  endtask
`endif

  task automatic test_random();
    logic acc, have, r;
    logic [1:0] op;
    int len;
    logic [5:0] o, e;
    have = 1'b0;
    op   = 2'd0;
    len  = 0;
    for (int i = 0; i < 600; i++) begin
      if (!have && $urandom_range(0, 2) != 0) begin
        have = 1'b1;
        op   = 2'($urandom_range(0, 3));
        len  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      end
      r = ($urandom_range(0, 99) != 0);
      drive_cycle(have, op, len, r, 1'b0, acc);
      if (acc || !r) have = 1'b0;
      o = obs_vec();
      e = exp_vec(cur);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b want=%b", cur, o, e);
      end
    end
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_len   = '0;
    q_in      = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_set();
    test_back_to_back();
    test_full();
    test_mid_reset();
`ifdef JK_SEQ_CHECK_EN
    test_checker();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
